// File: rtl/adc_serial_responder_if.sv
// Serial ADC link: CONVST/BUSY/CS/serial-clock/DATA.
//   master (reader side): drives convst, cs, sclk; receives busy, sdata.
//   slave  (ADC side)   : receives convst, cs, sclk; drives busy, sdata.
// cs is active low.
interface adc_serial_responder_if;
  logic convst;
  logic cs;
  logic sclk;
  logic busy;
  logic sdata;

  modport master (output convst, output cs, output sclk, input busy, input sdata);
  modport slave  (input convst, input cs, input sclk, output busy, output sdata);
endinterface

// File: rtl/adc_serial_responder.sv
// adc_serial_responder: synthesizable stand-in for a serial ADC.
// A convst rise starts a conversion of CONV_CYCLES clk cycles with busy high.
// At the end, sample_data is latched as the output word. A cs fall loads
// the word into a shift register, which is presented MSB-first on sdata and
// advanced on each sclk falling edge.
//
// Ports:
//   clk          system clock
//   nrst         asynchronous active-low reset
//   link         serial link, slave side (convst, cs, sclk in; busy, sdata out)
//   sample_data  value to be "converted", sampled at end of conversion
//   sample_valid high once any conversion has completed since reset
//   conv_missed  one-cycle pulse when a convst rise arrives mid-conversion
module adc_serial_responder #(
  parameter int DATA_W      = 16,
  parameter int CONV_CYCLES = 200
) (
  input  logic                  clk,
  input  logic                  nrst,
  adc_serial_responder_if.slave link,
  input  logic [DATA_W-1:0]     sample_data,
  output logic                  sample_valid,
  output logic                  conv_missed
);

  localparam int CNT_W = $clog2(CONV_CYCLES);
  localparam int BIT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CONV_CYCLES - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W);

  typedef enum logic {IDLE, CONVERT} state_t;

  // ---------------------------------------------------------------------------
  // Input synchronizers: [0],[1] form the 2-FF synchronizer, [2] holds the
  // previous synchronized value for edge detection.
  // ---------------------------------------------------------------------------
  logic [2:0] convst_sr;
  logic [2:0] cs_sr;
  logic [2:0] sclk_sr;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours, exactly like the hardware.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      convst_sr <= '0;
      cs_sr     <= '1;  // deselected, so leaving reset never looks like a cs fall
      sclk_sr   <= '0;
    end else begin
      convst_sr <= {convst_sr[1:0], link.convst};
      cs_sr     <= {cs_sr[1:0],     link.cs};
      sclk_sr   <= {sclk_sr[1:0],   link.sclk};
    end
  end

  logic convst_rise;
  logic cs_low;
  logic cs_fall;
  logic sclk_fall;

  assign convst_rise = convst_sr[1] & ~convst_sr[2];
  assign cs_low      = ~cs_sr[1];
  assign cs_fall     = ~cs_sr[1] & cs_sr[2];
  assign sclk_fall   = ~sclk_sr[1] & sclk_sr[2];

  // ---------------------------------------------------------------------------
  // Conversion FSM
  // ---------------------------------------------------------------------------
  state_t            state, state_next;
  logic [CNT_W-1:0]  conv_cnt, conv_cnt_next;
  logic              busy_q, busy_next;
  logic [DATA_W-1:0] dout_reg, dout_next;
  logic              valid_next;
  logic              missed_next;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state        <= IDLE;
      conv_cnt     <= '0;
      busy_q       <= 1'b0;
      dout_reg     <= '0;
      sample_valid <= 1'b0;
      conv_missed  <= 1'b0;
    end else begin
      state        <= state_next;
      conv_cnt     <= conv_cnt_next;
      busy_q       <= busy_next;
      dout_reg     <= dout_next;
      sample_valid <= valid_next;
      conv_missed  <= missed_next;
    end
  end

  // NOTE: every output of a combinational block gets a default first; any path
  // that leaves one unassigned would infer a latch.
  always_comb begin
    state_next    = state;
    conv_cnt_next = conv_cnt;
    busy_next     = busy_q;
    dout_next     = dout_reg;
    valid_next    = sample_valid;
    missed_next   = 1'b0;
    case (state)
      IDLE: begin
        if (convst_rise) begin
          state_next    = CONVERT;
          conv_cnt_next = '0;
          busy_next     = 1'b1;
        end
      end
      CONVERT: begin
        // A start request while converting is dropped but reported.
        if (convst_rise) missed_next = 1'b1;
        if (conv_cnt == CNT_LAST) begin
          dout_next  = sample_data;
          valid_next = 1'b1;
          busy_next  = 1'b0;
          state_next = IDLE;
        end else begin
          conv_cnt_next = conv_cnt + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign link.busy = busy_q;

  // ---------------------------------------------------------------------------
  // Serial readout, independent of the FSM. A cs fall on the same cycle as a
  // conversion end loads the old dout_reg, since dout_reg updates on that edge.
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] shift_reg, shift_next;
  logic [BIT_W-1:0]  bit_cnt, bit_cnt_next;
  logic              sdata_q, sdata_next;

  always_comb begin
    shift_next   = shift_reg;
    bit_cnt_next = bit_cnt;
    if (cs_fall) begin
      shift_next   = dout_reg;
      bit_cnt_next = '0;
    end else if (cs_low && sclk_fall && (bit_cnt < BIT_LAST)) begin
      shift_next   = {shift_reg[DATA_W-2:0], 1'b0};
      bit_cnt_next = bit_cnt + 1'b1;
    end
    // sdata is registered from the next shift value so a new bit appears on
    // the same edge the shift register loads or shifts, with no stale glitch.
    // Zero fill makes sdata 0 once all DATA_W bits have been shifted out.
    sdata_next = cs_low & shift_next[DATA_W-1];
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      shift_reg <= '0;
      bit_cnt   <= '0;
      sdata_q   <= 1'b0;
    end else begin
      shift_reg <= shift_next;
      bit_cnt   <= bit_cnt_next;
      sdata_q   <= sdata_next;
    end
  end

  assign link.sdata = sdata_q;

endmodule

// File: tb/tb_adc_serial_responder.sv
// Testbench for adc_serial_responder. Stimulus pushes expected responses into
// queues; monitor processes pop and compare when the DUT presents them:
//   bit_q    : sdata at each sclk rising edge while cs is low
//   busy_q   : length in clk cycles of each busy pulse
//   missed_q : length in clk cycles of each conv_missed pulse
module tb_adc_serial_responder;

  localparam int DATA_W = 16;
  localparam int CONV   = 200;

  logic              clk;
  logic              nrst;
  logic [DATA_W-1:0] sample_data;
  logic              sample_valid;
  logic              conv_missed;

  adc_serial_responder_if bus ();

  adc_serial_responder #(.DATA_W(DATA_W), .CONV_CYCLES(CONV)) dut (
    .clk          (clk),
    .nrst         (nrst),
    .link         (bus.slave),
    .sample_data  (sample_data),
    .sample_valid (sample_valid),
    .conv_missed  (conv_missed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic bit_q[$];
  int   busy_q[$];
  int   missed_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // ---------------------------------------------------------------------------
  // Monitors
  // ---------------------------------------------------------------------------
  always @(posedge bus.sclk) begin
    if (nrst && !bus.cs) begin
      if (bit_q.size() == 0) check("unexpected_sdata_sample", 32'(bit_q.size()), 32'd1);
      else check("sdata_bit", 32'(bus.sdata), 32'(bit_q.pop_front()));
    end
  end

  int busy_cnt = 0;
  always @(negedge clk) begin
    if (!nrst) busy_cnt = 0;
    else if (bus.busy) busy_cnt++;
    else if (busy_cnt != 0) begin
      if (busy_q.size() == 0) check("unexpected_busy_pulse", 32'(busy_q.size()), 32'd1);
      else check("busy_width", 32'(busy_cnt), 32'(busy_q.pop_front()));
      busy_cnt = 0;
    end
  end

  int missed_cnt = 0;
  always @(negedge clk) begin
    if (!nrst) missed_cnt = 0;
    else if (conv_missed) missed_cnt++;
    else if (missed_cnt != 0) begin
      if (missed_q.size() == 0) check("unexpected_missed_pulse", 32'(missed_q.size()), 32'd1);
      else check("missed_width", 32'(missed_cnt), 32'(missed_q.pop_front()));
      missed_cnt = 0;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  // Raises convst and checks busy appears exactly 3 clk cycles later.
  task automatic start_conv(input logic [DATA_W-1:0] value, input bit expect_full);
    sample_data = value;
    if (expect_full) busy_q.push_back(CONV);
    bus.convst = 1'b1;
    tick(2);
    check("busy_before_sync", 32'(bus.busy), 32'd0);
    tick(1);
    check("busy_after_sync", 32'(bus.busy), 32'd1);
    tick(1);
    bus.convst = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 2 * CONV && bus.busy; i++) tick(1);
    check("busy_fall_in_time", 32'(bus.busy), 32'd0);
    check("sample_valid_after_conv", 32'(sample_valid), 32'd1);
  endtask

  task automatic cs_low();
    bus.cs = 1'b0;
    tick(5);
  endtask

  task automatic cs_high();
    bus.cs = 1'b1;
    tick(5);
  endtask

  // n sclk periods of 10 clk, starting at bit index first of word.
  task automatic read_bits(input logic [DATA_W-1:0] word, input int first, input int n);
    logic [DATA_W-1:0] w;
    w = word;
    for (int i = 0; i < n; i++) begin
      if (first + i < DATA_W) bit_q.push_back(w[DATA_W-1-(first+i)]);
      else bit_q.push_back(1'b0);
      bus.sclk = 1'b1;
      tick(5);
      bus.sclk = 1'b0;
      tick(5);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    nrst        = 1'b0;
    bus.convst  = 1'b0;
    bus.cs      = 1'b1;
    bus.sclk    = 1'b0;
    sample_data = '0;
    tick(3);
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_sdata", 32'(bus.sdata), 32'd0);
    check("reset_sample_valid", 32'(sample_valid), 32'd0);
    check("reset_conv_missed", 32'(conv_missed), 32'd0);
    nrst = 1'b1;
    tick(3);

    // First conversion and full 17-period read.
    start_conv(16'hA5C3, 1'b1);
    wait_done();
    cs_low();
    read_bits(16'hA5C3, 0, DATA_W + 1);
    cs_high();

    // convst again 50 cycles into a conversion of 16'h1234.
    start_conv(16'h1234, 1'b1);
    tick(46);
    missed_q.push_back(1);
    bus.convst = 1'b1;
    tick(4);
    bus.convst = 1'b0;
    wait_done();

    // New conversion completes mid-read: remaining bits still from 16'h1234.
    cs_low();
    read_bits(16'h1234, 0, 8);
    start_conv(16'hFFFF, 1'b1);
    wait_done();
    read_bits(16'h1234, 8, 8);
    cs_high();
    cs_low();
    read_bits(16'hFFFF, 0, DATA_W);
    cs_high();

    // Aborted read restarts from the MSB; sclk with cs high is ignored.
    start_conv(16'h8C01, 1'b1);
    wait_done();
    cs_low();
    read_bits(16'h8C01, 0, 5);
    cs_high();
    for (int i = 0; i < 3; i++) begin
      bus.sclk = 1'b1;
      tick(5);
      check("sdata_cs_high", 32'(bus.sdata), 32'd0);
      bus.sclk = 1'b0;
      tick(5);
    end
    cs_low();
    read_bits(16'h8C01, 0, DATA_W);
    cs_high();

    // Reset 100 cycles into a conversion discards it.
    start_conv(16'hBEEF, 1'b0);
    tick(96);
    #2;
    nrst = 1'b0;
    #1;
    check("rst_mid_busy", 32'(bus.busy), 32'd0);
    check("rst_mid_sample_valid", 32'(sample_valid), 32'd0);
    check("rst_mid_sdata", 32'(bus.sdata), 32'd0);
    tick(2);
    nrst = 1'b1;
    tick(2);
    cs_low();
    read_bits(16'h0000, 0, DATA_W);
    cs_high();
    check("post_rst_sample_valid", 32'(sample_valid), 32'd0);
    check("post_rst_busy", 32'(bus.busy), 32'd0);

    tick(10);
    check("bit_q_drained", 32'(bit_q.size()), 32'd0);
    check("busy_q_drained", 32'(busy_q.size()), 32'd0);
    check("missed_q_drained", 32'(missed_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
